// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
// Runs a WIDTH-bit ALU operation through one external 4-bit slice, one nibble
// per clock, LSB nibble first, rippling the carry through a register.
// Optional build macro: ALU_SEQ_FLAGS_EN adds registered zero_o/neg_o flags.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start_i; last result/cout held
// S_RUN  | one slice pass per cycle, nibble idx_q presented to slice
// S_DONE | done_o high for one cycle, result_o/cout_o valid
module alu_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       s_i,
  input  logic             m_i,
  input  logic             cin_i,
  output logic [3:0]       slice_a_o,
  output logic [3:0]       slice_b_o,
  output logic             slice_cin_o,
  output logic [3:0]       slice_s_o,
  output logic             slice_m_o,
  input  logic [3:0]       slice_o_i,
  input  logic             slice_cout_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             zero_o,
  output logic             neg_o
`endif
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] merged;
`ifdef ALU_SEQ_FLAGS_EN
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
`endif

  // State and datapath registers; reset clears everything including latched operands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q   <= zero_d;
      neg_q    <= neg_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, merge one slice nibble per RUN cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef ALU_SEQ_FLAGS_EN
    zero_d   = zero_q;
    neg_d    = neg_q;
`endif
    // Result with the current slice nibble dropped in; this is also the
    // full assembled word on the final pass, so the flags derive from it.
    merged = result_q;
    merged[4*idx_q +: 4] = slice_o_i;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d      = a_i;
          b_d      = b_i;
          s_d      = s_i;
          m_d      = m_i;
          carry_d  = cin_i;
          idx_d    = '0;
          result_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        result_d = merged;
        carry_d  = slice_cout_i;
        if (idx_q == IDX_LAST) begin
          // idx holds at the last nibble rather than wrapping.
          cout_d  = m_q ? 1'b0 : slice_cout_i;
`ifdef ALU_SEQ_FLAGS_EN
          zero_d  = (merged == '0);
          neg_d   = merged[WIDTH-1];
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Slice drive and status outputs; operand nibbles only presented while running.
  always_comb begin
    slice_a_o   = '0;
    slice_b_o   = '0;
    if (state_q == S_RUN) begin
      slice_a_o = a_q[4*idx_q +: 4];
      slice_b_o = b_q[4*idx_q +: 4];
    end
    slice_cin_o = carry_q;
    slice_s_o   = s_q;
    slice_m_o   = m_q;
    busy_o      = (state_q == S_RUN);
    done_o      = (state_q == S_DONE);
    result_o    = result_q;
    cout_o      = cout_q;
`ifdef ALU_SEQ_FLAGS_EN
    zero_o      = zero_q;
    neg_o       = neg_q;
`endif
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer (WIDTH=16) with a behavioural 4-bit
// 181-style slice in place of alu_4bit; results compared with a word-level
// reference computed in one step.
module tb_alu_nibble_sequencer;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in, b_in;
  logic [3:0]       s_in;
  logic             m_in, cin_in;
  logic [3:0]       sl_a, sl_b, sl_s, sl_o;
  logic             sl_cin, sl_m, sl_cout;
  logic             busy, done, cout;
  logic [WIDTH-1:0] result;
`ifdef ALU_SEQ_FLAGS_EN
  logic             zero, neg;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .a_i          (a_in),
    .b_i          (b_in),
    .s_i          (s_in),
    .m_i          (m_in),
    .cin_i        (cin_in),
    .slice_a_o    (sl_a),
    .slice_b_o    (sl_b),
    .slice_cin_o  (sl_cin),
    .slice_s_o    (sl_s),
    .slice_m_o    (sl_m),
    .slice_o_i    (sl_o),
    .slice_cout_i (sl_cout),
    .busy_o       (busy),
    .done_o       (done),
    .result_o     (result),
    .cout_o       (cout)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .zero_o       (zero),
    .neg_o        (neg)
`endif
  );

  function automatic logic [15:0] logic_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s);
    case (s)
      4'h0: return ~a;
      4'h1: return ~(a | b);
      4'h2: return ~a & b;
      4'h3: return 16'h0000;
      4'h4: return ~(a & b);
      4'h5: return ~b;
      4'h6: return a ^ b;
      4'h7: return a & ~b;
      4'h8: return ~a | b;
      4'h9: return ~(a ^ b);
      4'hA: return b;
      4'hB: return a & b;
      4'hC: return 16'hFFFF;
      4'hD: return a | ~b;
      4'hE: return a | b;
      default: return a;
    endcase
  endfunction

  // Arithmetic mode is X + Y + cin with X/Y bitwise functions of A and B.
  function automatic logic [31:0] arith_xy(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] s);
    case (s)
      4'h0: return {a, 16'h0000};
      4'h1: return {a | b, 16'h0000};
      4'h2: return {a | ~b, 16'h0000};
      4'h3: return {16'hFFFF, 16'h0000};
      4'h4: return {a, a & ~b};
      4'h5: return {a | b, a & ~b};
      4'h6: return {a, ~b};
      4'h7: return {a & ~b, 16'hFFFF};
      4'h8: return {a, a & b};
      4'h9: return {a, b};
      4'hA: return {a | ~b, a & b};
      4'hB: return {a & b, 16'hFFFF};
      4'hC: return {a, a};
      4'hD: return {a | b, a};
      4'hE: return {a | ~b, a};
      default: return {a, 16'hFFFF};
    endcase
  endfunction

  // Whole-word reference: {cout, result}
  function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] s, input logic m, input logic cin);
    logic [31:0] xy;
    if (m) return {1'b0, logic_f(a, b, s)};
    xy = arith_xy(a, b, s);
    return {1'b0, xy[31:16]} + {1'b0, xy[15:0]} + {16'h0000, cin};
  endfunction

  logic [15:0] sl_lf;
  logic [31:0] sl_xy;
  logic [4:0]  sl_sum;

  // Behavioural 4-bit slice, purely combinational from the sequencer outputs.
  always_comb begin
    sl_lf  = logic_f({12'h000, sl_a}, {12'h000, sl_b}, sl_s);
    sl_xy  = arith_xy({12'h000, sl_a}, {12'h000, sl_b}, sl_s);
    sl_sum = {1'b0, sl_xy[19:16]} + {1'b0, sl_xy[3:0]} + {4'h0, sl_cin};
    if (sl_m) begin
      sl_o    = sl_lf[3:0];
      sl_cout = 1'b0;
    end else begin
      sl_o    = sl_sum[3:0];
      sl_cout = sl_sum[4];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " result"}, result, 0);
    check({tag, " cout"}, cout, 0);
    check({tag, " slice_a"}, sl_a, 0);
    check({tag, " slice_b"}, sl_b, 0);
    check({tag, " slice_cin"}, sl_cin, 0);
    check({tag, " slice_s"}, sl_s, 0);
    check({tag, " slice_m"}, sl_m, 0);
`ifdef ALU_SEQ_FLAGS_EN
    check({tag, " zero"}, zero, 0);
    check({tag, " neg"}, neg, 0);
`endif
  endtask

  // Launch one operation; optionally poke start during RUN, or reset in the 3rd RUN cycle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] s, input logic m, input logic cin,
                        input int poke_cyc, input bit do_rst);
    logic [16:0] exp;
    logic [15:0] sh;
    int c;
    exp    = ref_op(a, b, s, m, cin);
    start  = 1'b1;
    a_in   = a;
    b_in   = b;
    s_in   = s;
    m_in   = m;
    cin_in = cin;
    tick();
    start  = 1'b0;
    a_in   = 16'($urandom);
    b_in   = 16'($urandom);
    s_in   = 4'($urandom);
    m_in   = 1'($urandom);
    cin_in = 1'($urandom);
    c = 0;
    while (done !== 1'b1 && c < 20) begin
      check({tag, " busy"}, busy, 1);
      if (c < NIB) begin
        sh = a >> (4 * c);
        check({tag, " slice_a"}, sl_a, sh[3:0]);
        sh = b >> (4 * c);
        check({tag, " slice_b"}, sl_b, sh[3:0]);
      end
      if (c == 0) begin
        check({tag, " slice_cin"}, sl_cin, cin);
        check({tag, " slice_s"}, sl_s, s);
        check({tag, " slice_m"}, sl_m, m);
      end
      start = (c == poke_cyc);
      if (do_rst && c == 2) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check({tag, " rst busy"}, busy, 0);
        check({tag, " rst done"}, done, 0);
        check({tag, " rst result"}, result, 0);
        check({tag, " rst cout"}, cout, 0);
        repeat (NIB + 2) begin
          tick();
          check({tag, " no done after rst"}, done, 0);
        end
        return;
      end
      tick();
      c++;
    end
    start = 1'b0;
    check({tag, " latency"}, c, NIB);
    check({tag, " done"}, done, 1);
    check({tag, " busy at done"}, busy, 0);
    check({tag, " result"}, result, exp[15:0]);
    check({tag, " cout"}, cout, exp[16]);
`ifdef ALU_SEQ_FLAGS_EN
    check({tag, " zero"}, zero, (exp[15:0] == 16'h0000));
    check({tag, " neg"}, neg, exp[15]);
`endif
    tick();
    check({tag, " done one cycle"}, done, 0);
    check({tag, " result held"}, result, exp[15:0]);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    s_in   = '0;
    m_in   = 1'b0;
    cin_in = 1'b0;
    repeat (3) tick();
    check_idle_reset("reset");
    rst = 1'b0;
    tick();

    run_op("add_carry_ripple", 16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, -1, 1'b0);
    run_op("add_overflow",     16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, -1, 1'b0);
    run_op("transfer_plus_cin", 16'h000F, 16'hAAAA, 4'b0000, 1'b0, 1'b1, -1, 1'b0);
    run_op("xor_logic",        16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, -1, 1'b0);
    run_op("sub_a_minus_b",    16'h8000, 16'h0001, 4'b0110, 1'b0, 1'b1, -1, 1'b0);

    // start pulse two cycles into RUN with different operands must be ignored
    a_in = 16'h1234;
    run_op("ignored_start",    16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b0, 2, 1'b0);

    run_op("rst_abort",        16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0, -1, 1'b1);
    check_idle_reset("after_abort");
    run_op("after_abort_op",   16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, -1, 1'b0);

    // rst and start together: rst wins
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 16'hABCD;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_beats_start busy", busy, 0);
    check("rst_beats_start result", result, 0);
    tick();
    check("rst_beats_start stays idle", busy, 0);

    for (int i = 0; i < 40; i++) begin
      run_op("random", 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
             1'($urandom), -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
